// File: rtl/mac_accum16_pkg.sv
// Shared definitions for the mac_accum16 multiply-accumulate block:
// FSM state encoding, default widths and multiplier operand/product widths.
package mac_accum16_pkg;

  // Default accumulator width (legal range 32..48) and beat-counter width.
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  // Operand and full-product widths of the 16x16 multiplier.
  localparam int MUL_W  = 16;
  localparam int PROD_W = 2 * MUL_W;

  // Frame-level FSM:
  //   ST_ACC   - accepting beats, accumulating products
  //   ST_DRAIN - last beat taken, its product still in flight
  //   ST_HOLD  - result presented, waiting for the consumer
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage : mac_accum16_pkg

// File: rtl/mac_accum16_mult16bit.sv
// mult16bit: combinational 16x16 unsigned array multiplier.
// Each row of the array is the multiplicand gated by one multiplier bit,
// shifted into place and added to the running row sum.
module mult16bit
  import mac_accum16_pkg::*;
(
  input  logic [MUL_W-1:0]  i_a,
  input  logic [MUL_W-1:0]  i_b,
  output logic [PROD_W-1:0] o_prod
);

  logic [PROD_W-1:0] w_row_sum;

  // Ripple the partial-product rows down the array, LSB row first.
  always_comb begin
    // NOTE: blocking '=' is correct inside always_comb; each row must see the
    // previous row's sum within the same evaluation, and the default first
    // assignment guarantees no latch is inferred.
    w_row_sum = '0;
    for (int i = 0; i < MUL_W; i++) begin
      w_row_sum = w_row_sum
                + ({{MUL_W{1'b0}}, i_a & {MUL_W{i_b[i]}}} << i);
    end
  end

  assign o_prod = w_row_sum;

endmodule : mult16bit

// File: rtl/mac_accum16.sv
// mac_accum16: streaming 16x16 unsigned multiply-accumulate.
// Beats (a, b) are accepted in frames terminated by in_last. Each product is
// registered at the accept edge and added into the accumulator one edge
// later, so back-to-back beats overlap. After the final product lands the
// sum, saturating beat count and sticky overflow are held until consumed.
module mac_accum16
  import mac_accum16_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             ovf
);

  // Reject accumulator widths the datapath is not built for.
  if (ACC_W < 32 || ACC_W > 48) begin : g_acc_w_check
    $error("mac_accum16: ACC_W must lie in 32..48");
  end

  state_t            r_state;
  state_t            w_next_state;

  logic              w_accept;
  logic              w_consume;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;
  logic              w_cnt_sat;

  logic [PROD_W-1:0] r_prod_q;
  logic              r_prod_v;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  // One extra bit above the accumulator captures the carry for ovf.
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(r_prod_q);
  assign w_cnt_sat = &r_cnt;

  // Single shared array multiplier forms the beat product.
  mult16bit u_mult (
    .i_a    (a),
    .i_b    (b),
    .o_prod (w_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of process ordering.
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_ACC:   if (w_accept && in_last) w_next_state = ST_DRAIN;
      // The product of the last beat is always pending here, so one edge
      // suffices to fold it in.
      ST_DRAIN: w_next_state = ST_HOLD;
      ST_HOLD:  if (out_ready) w_next_state = ST_ACC;
      default:  w_next_state = ST_ACC;
    endcase
  end

  // FSM outputs: handshake signals decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ST_ACC:   in_ready  = 1'b1;
      ST_DRAIN: in_ready  = 1'b0;
      ST_HOLD:  out_valid = 1'b1;
      default:  in_ready  = 1'b0;
    endcase
  end

  // Product pipeline stage: capture the product on accept, flag it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_q <= '0;
      r_prod_v <= 1'b0;
    end else if (w_consume) begin
      r_prod_v <= 1'b0;
    end else begin
      r_prod_v <= w_accept;
      if (w_accept) begin
        r_prod_q <= w_prod;
      end
    end
  end

  // Accumulator with sticky overflow; wraps modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_consume) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_prod_v) begin
      r_acc <= w_sum[ACC_W-1:0];
      if (w_sum[ACC_W]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Saturating count of beats accepted in the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_consume) begin
      r_cnt <= '0;
    end else if (w_accept && !w_cnt_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign acc_out  = r_acc;
  assign beat_cnt = r_cnt;
  assign ovf      = r_ovf;

endmodule : mac_accum16

// File: tb/tb_mac_accum16.sv
// Directed bench for mac_accum16: a table of uniform frames applied to a
// 40-bit and a 32-bit instance in parallel, plus hand-written sequences for
// backpressure in HOLD and reset mid-frame.
module tb_mac_accum16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_last;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [39:0] acc_out;
  logic [7:0]  beat_cnt;
  logic        ovf;

  logic        in_ready32;
  logic        out_valid32;
  logic [31:0] acc_out32;
  logic [7:0]  beat_cnt32;
  logic        ovf32;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned beats;
    logic [15:0] a;
    logic [15:0] b;
    logic [39:0] exp_acc;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
    logic [31:0] exp_acc32;
    logic        exp_ovf32;
  } vec_t;

  vec_t vecs [7];

  mac_accum16 #(.ACC_W(40), .CNT_W(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .beat_cnt  (beat_cnt),
    .ovf       (ovf)
  );

  mac_accum16 #(.ACC_W(32), .CNT_W(8)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .acc_out   (acc_out32),
    .beat_cnt  (beat_cnt32),
    .ovf       (ovf32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready"},  64'(in_ready),  64'd1);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " acc_out"},   64'(acc_out),   64'd0);
    check({tag, " beat_cnt"},  64'(beat_cnt),  64'd0);
    check({tag, " ovf"},       64'(ovf),       64'd0);
    check({tag, " acc_out32"}, 64'(acc_out32), 64'd0);
    check({tag, " ovf32"},     64'(ovf32),     64'd0);
  endtask

  // Drive one frame back-to-back from a negedge, check the exact result
  // latency and values, then consume it. Returns at a negedge.
  task automatic run_frame(input string tag, input vec_t v);
    check({tag, " in_ready first beat"}, 64'(in_ready), 64'd1);
    for (int unsigned i = 0; i < v.beats; i++) begin
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      in_last  = (i == v.beats - 1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    // One cycle after the last accept: draining, no result yet.
    check({tag, " out_valid @k"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready @k"},  64'(in_ready),  64'd0);
    @(negedge clk);
    check({tag, " out_valid @k+1"},   64'(out_valid),   64'd1);
    check({tag, " out_valid32 @k+1"}, 64'(out_valid32), 64'd1);
    check({tag, " acc_out"},   64'(acc_out),   64'(v.exp_acc));
    check({tag, " beat_cnt"},  64'(beat_cnt),  64'(v.exp_cnt));
    check({tag, " ovf"},       64'(ovf),       64'(v.exp_ovf));
    check({tag, " acc_out32"}, 64'(acc_out32), 64'(v.exp_acc32));
    check({tag, " ovf32"},     64'(ovf32),     64'(v.exp_ovf32));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_idle({tag, " after consume"});
  endtask

  initial begin
    //           beats  a         b         exp_acc40          cnt   ovf  exp_acc32       ovf32
    vecs[0] = '{ 1,   16'd3,    16'd5,    40'd15,            8'd1,   1'b0, 32'd15,         1'b0};
    vecs[1] = '{ 4,   16'hFFFF, 16'hFFFF, 40'h3_FFF8_0004,   8'd4,   1'b0, 32'hFFF8_0004,  1'b1};
    vecs[2] = '{ 2,   16'hFFFF, 16'hFFFF, 40'h1_FFFC_0002,   8'd2,   1'b0, 32'hFFFC_0002,  1'b1};
    vecs[3] = '{ 300, 16'd1,    16'd1,    40'd300,           8'd255, 1'b0, 32'd300,        1'b0};
    vecs[4] = '{ 3,   16'h1234, 16'h0010, 40'h3_69C0,        8'd3,   1'b0, 32'h0003_69C0,  1'b0};
    vecs[5] = '{ 1,   16'h0000, 16'hFFFF, 40'd0,             8'd1,   1'b0, 32'd0,          1'b0};
    vecs[6] = '{ 5,   16'h8000, 16'h8000, 40'h1_4000_0000,   8'd5,   1'b0, 32'h4000_0000,  1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // Table-driven frames; the first accept lands on the first edge after
    // reset release.
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("v%0d", i), vecs[i]);
    end

    // Backpressure: result held for 5 cycles, beats offered in HOLD ignored.
    in_valid = 1'b1;
    in_last  = 1'b1;
    a        = 16'd7;
    b        = 16'd9;
    @(posedge clk);
    @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d out_valid", c), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d in_ready", c),  64'(in_ready),  64'd0);
      check($sformatf("bp%0d acc_out", c),   64'(acc_out),   64'd63);
      check($sformatf("bp%0d beat_cnt", c),  64'(beat_cnt),  64'd1);
      check($sformatf("bp%0d ovf", c),       64'(ovf),       64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check_idle("bp after consume");

    // Reset after 3 of 5 beats discards the partial frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_last  = 1'b0;
      a        = 16'd1;
      b        = 16'd1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_idle("mid-frame reset");
    @(negedge clk);
    check("reset hold out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    run_frame("post-reset", '{1, 16'd2, 16'd2, 40'd4, 8'd1, 1'b0, 32'd4, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mac_accum16

// File: doc/mac_accum16.md
MAC_ACCUM16 -- requirements
Module: mac_accum16

Interface
REQ-001 Parameter ACC_W, default 40: accumulator and result width, legal range 32..48.
REQ-002 Parameter CNT_W, default 8: beat-counter width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1: operand beat present.
REQ-006 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 Port a, input, 16: unsigned multiplicand.
REQ-008 Port b, input, 16: unsigned multiplier.
REQ-009 Port in_last, input, 1: marks the final beat of a frame; sampled only on accept.
REQ-010 Port out_valid, output, 1: frame result available.
REQ-011 Port out_ready, input, 1: consumer takes the result.
REQ-012 Port acc_out, output, ACC_W: sum of a*b over the frame, modulo 2^ACC_W.
REQ-013 Port beat_cnt, output, CNT_W: beats accepted in the frame, saturating.
REQ-014 Port ovf, output, 1: sticky flag; the frame sum exceeded 2^ACC_W-1.

Function
REQ-015 An accept occurs on a rising edge where in_valid and in_ready are both 1.
REQ-016 The combinational 16x16 unsigned product of a and b is registered into prod_q, with prod_v set, at the accept edge k.
REQ-017 At edge k+1, when prod_v is 1, acc = (acc + zero-extended prod_q) mod 2^ACC_W; the carry out of bit ACC_W-1 sets ovf.
REQ-018 The FSM has three states: ACC (in_ready=1), DRAIN (in_ready=0), HOLD (in_ready=0, out_valid=1).
REQ-019 In ACC, an accept with in_last=0 stays in ACC; back-to-back accepts every cycle are supported, with product registration and accumulation overlapping.
REQ-020 In ACC, an accept with in_last=1 moves to DRAIN at edge k.
REQ-021 DRAIN moves to HOLD at edge k+1, when the last product is accumulated; out_valid is therefore 1 from the cycle after k+1 (two cycles after the accept).
REQ-022 In HOLD, acc_out, beat_cnt and ovf are held stable while out_ready is 0.
REQ-023 In HOLD, out_valid and out_ready both 1 returns the FSM to ACC at that edge, clearing acc, beat_cnt, ovf and prod_v; a new beat can be accepted on the following edge.
REQ-024 beat_cnt increments on each accept and saturates at 2^CNT_W-1, with no wrap.
REQ-025 ovf, once set, stays 1 until the frame is consumed or reset; acc continues to wrap modulo 2^ACC_W.
REQ-026 Outside HOLD, acc_out shows the running accumulator and out_valid is 0.
REQ-027 in_valid and in_last have no effect in DRAIN and HOLD.

Reset
REQ-028 rst_n low immediately forces: state=ACC, in_ready=1, out_valid=0, acc_out=0, beat_cnt=0, ovf=0, prod_q=0, prod_v=0.
REQ-029 Reset asserted mid-frame or in HOLD discards the partial frame; no result is emitted for it.
REQ-030 Reset deassertion is synchronous to clk at the integration level; the first accept may occur on the first edge after release.

Structure
REQ-031 A shared package holds the FSM state enum (ACC, DRAIN, HOLD) and the default ACC_W and CNT_W constants.
REQ-032 The product is formed by exactly one instance of the team's combinational 16x16 array multiplier, mult16bit; mac_accum16 adds no multiplier logic of its own.

Verification
REQ-033 Single beat a=3, b=5, last=1: out_valid rises two cycles after the accept with acc_out=15, beat_cnt=1, ovf=0.
REQ-034 Four back-to-back beats of 0xFFFF*0xFFFF, last on the 4th: acc_out=0x3_FFF8_0004, beat_cnt=4, ovf=0.
REQ-035 ACC_W=32, two beats of 0xFFFF*0xFFFF: acc_out=0xFFFC_0002, ovf=1.
REQ-036 Backpressure: out_ready held 0 for 5 cycles in HOLD: outputs unchanged and in_ready=0 throughout; handshake on cycle 6 returns to ACC and clears all result outputs.
REQ-037 300 beats of 1*1 with CNT_W=8: beat_cnt=255, acc_out=300.
REQ-038 Reset pulse after 3 of 5 beats: outputs at reset values; a following 1-beat frame 2*2 yields acc_out=4, beat_cnt=1.
